// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker program loader.
package tinker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [63:0] TINKER_CODE_BASE = 64'h2000;
  localparam int unsigned TINKER_MEM_BYTES = 524288;

endpackage

// File: rtl/tinker_program_loader_if.sv
// Byte-stream handshake between an image source (master) and the loader (slave).
interface tinker_program_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/tinker_program_loader_le_byte_packer.sv
// Little-endian byte packer: byte k of a word lands in bits [8k+7:8k].
// word_next shows the word with data inserted at the current index, so the
// caller can capture a completed word in the same cycle as its final byte.
module le_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [1:0]  idx,
  output logic [31:0] word,
  output logic [31:0] word_next
);

  // Insert the incoming byte at the current index.
  always_comb begin
    word_next = word;
    word_next[{idx, 3'b000} +: 8] = data;
  end

  // Index counter and packed word; clear wins over load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop updates from pre-edge values.
    if (reset || clear) begin
      idx  <= 2'd0;
      word <= 32'd0;
    end else if (load) begin
      idx  <= idx + 2'd1;
      word <= word_next;
    end
  end

endmodule

// File: rtl/tinker_program_loader.sv
// Tinker program loader: packs a byte stream into 32-bit words, writes them
// from BASE_ADDR upward, and holds the core in reset until the image is in.
// Optional running byte checksum enabled by defining TINKER_LOADER_CHECKSUM_EN.
module tinker_program_loader
  import tinker_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = TINKER_CODE_BASE,
  parameter int unsigned MEM_BYTES = TINKER_MEM_BYTES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  tinker_program_loader_if.slave   src,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     core_reset,
  output logic                     done,
  output logic                     error,
  output logic [31:0]              words_written,
  output logic [7:0]               checksum
);

  loader_state_t state_q, state_d;

  logic        accept;
  logic        start_load;
  logic        close_word;
  logic        last_q;
  logic        overflow;
  logic [1:0]  byte_idx;
  logic [31:0] packed_word;
  logic [31:0] packed_next;
  logic [31:0] addr32;
  logic [63:0] word_addr;

  assign accept     = src.in_valid & src.in_ready;
  assign start_load = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign close_word = accept && (byte_idx == 2'd3 || src.in_last);

  // Full-width address for the overflow test; the bus address is truncated.
  assign word_addr = BASE_ADDR + {30'd0, words_written, 2'b00};
  assign overflow  = (word_addr + 64'd3) >= 64'(MEM_BYTES);
  assign addr32    = BASE_ADDR[31:0] + {words_written[29:0], 2'b00};

  le_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_load || state_q == WRITE),
    .load      (accept),
    .data      (src.in_data),
    .idx       (byte_idx),
    .word      (packed_word),
    .word_next (packed_next)
  );

  // Next-state selection.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (close_word) state_d = overflow ? ERR : WRITE;
      WRITE:   state_d = last_q ? DONE : COLLECT;
      DONE:    if (start) state_d = COLLECT;
      ERR:     if (start) state_d = COLLECT;
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      src.in_ready  <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      core_reset    <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= 32'd0;
      last_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      src.in_ready <= (state_d == COLLECT);
      mem_we       <= (state_d == WRITE);
      core_reset   <= (state_d != DONE);
      done         <= (state_d == DONE);
      error        <= (state_d == ERR);
      if (state_q == COLLECT && state_d == WRITE) begin
        mem_addr  <= addr32;
        mem_wdata <= packed_next;
      end
      if (start_load) begin
        words_written <= 32'd0;
        last_q        <= 1'b0;
      end else begin
        if (state_q == WRITE) words_written <= words_written + 32'd1;
        if (accept && src.in_last) last_q <= 1'b1;
        else if (state_q == WRITE) last_q <= 1'b0;
      end
    end
  end

`ifdef TINKER_LOADER_CHECKSUM_EN
  // Running mod-256 sum of accepted bytes, cleared when a load starts.
  always_ff @(posedge clk) begin
    if (reset || start_load) checksum <= 8'h00;
    else if (accept)         checksum <= checksum + src.in_data;
  end
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_tinker_program_loader.sv
// Directed bench for tinker_program_loader with a write scoreboard.
// A second instance with a 0x2008-byte memory exercises overflow.
module tb_tinker_program_loader;
  logic clk;
  logic reset;
  logic start1, start2;

  tinker_program_loader_if s1 ();
  tinker_program_loader_if s2 ();

  logic        we1, we2;
  logic [31:0] addr1, addr2, wdata1, wdata2, ww1, ww2;
  logic        crst1, crst2, done1, done2, err1, err2;
  logic [7:0]  cks1, cks2;

  tinker_program_loader dut (
    .clk(clk), .reset(reset), .start(start1), .src(s1.slave),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .core_reset(crst1),
    .done(done1), .error(err1), .words_written(ww1), .checksum(cks1)
  );

  tinker_program_loader #(.MEM_BYTES(32'h2008)) dut_small (
    .clk(clk), .reset(reset), .start(start2), .src(s2.slave),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2), .core_reset(crst2),
    .done(done2), .error(err2), .words_written(ww2), .checksum(cks2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  logic [63:0] exp1_q[$], exp2_q[$], obs1_q[$], obs2_q[$];

  // Monitor: record every write, and any cycle where a write overlaps in_ready.
  always @(negedge clk) begin
    if (we1) obs1_q.push_back({addr1, wdata1});
    if (we2) obs2_q.push_back({addr2, wdata2});
    if ((we1 && s1.in_ready) || (we2 && s2.in_ready)) viol++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Present one byte and hold it until the loader takes it (bounded).
  task automatic send(input bit sel, input logic [7:0] d, input logic last);
    int budget = 50;
    if (sel) begin s2.in_valid = 1'b1; s2.in_data = d; s2.in_last = last; end
    else     begin s1.in_valid = 1'b1; s1.in_data = d; s1.in_last = last; end
    while (((sel ? s2.in_ready : s1.in_ready) !== 1'b1) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_tests++; n_fail++;
      $error("FAIL send_timeout: byte %0h never accepted", d);
    end
    @(negedge clk);
    s1.in_valid = 1'b0; s1.in_last = 1'b0;
    s2.in_valid = 1'b0; s2.in_last = 1'b0;
  endtask

  // Wait for done (sel=0) or error on the small instance (sel=1), bounded.
  task automatic wait_flag(input bit sel, input string tag);
    int budget = 100;
    while (((sel ? err2 : done1) !== 1'b1) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_tests++; n_fail++;
      $error("FAIL %s: flag never rose, observed 0 expected 1", tag);
    end
  endtask

  // Pop expected writes against observed writes; nothing may be left over.
  task automatic check_writes(input bit sel, input string tag);
    logic [63:0] e, o;
    while ((sel ? exp2_q.size() : exp1_q.size()) > 0) begin
      e = sel ? exp2_q.pop_front() : exp1_q.pop_front();
      if ((sel ? obs2_q.size() : obs1_q.size()) == 0) begin
        n_tests++; n_fail++;
        $error("FAIL %s: missing write, observed none expected %0h", tag, e);
      end else begin
        o = sel ? obs2_q.pop_front() : obs1_q.pop_front();
        check(tag, o, e);
      end
    end
    check({tag, "_extra"}, sel ? obs2_q.size() : obs1_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
    s1.in_valid = 1'b0; s1.in_data = 8'h00; s1.in_last = 1'b0;
    s2.in_valid = 1'b0; s2.in_data = 8'h00; s2.in_last = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_in_ready", s1.in_ready, 0);
    check("rst_mem_we", we1, 0);
    check("rst_mem_addr", addr1, 0);
    check("rst_mem_wdata", wdata1, 0);
    check("rst_core_reset", crst1, 1);
    check("rst_done", done1, 0);
    check("rst_error", err1, 0);
    check("rst_words", ww1, 0);
    check("rst_checksum", cks1, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single full word
    pulse_start(0);
    exp1_q.push_back({32'h2000, 32'hDF9B5713});
    send(0, 8'h13, 0); send(0, 8'h57, 0); send(0, 8'h9B, 0); send(0, 8'hDF, 1);
    wait_flag(0, "t1_done");
    check("t1_done", done1, 1);
    check("t1_core_reset", crst1, 0);
    check("t1_in_ready", s1.in_ready, 0);
    check("t1_words", ww1, 1);
`ifdef TINKER_LOADER_CHECKSUM_EN
    check("t1_checksum", cks1, 8'hE4);
`else
    check("t1_checksum", cks1, 8'h00);
`endif
    check_writes(0, "t1_write");

    // Partial final word
    pulse_start(0);
    check("t2_core_reset_held", crst1, 1);
    check("t2_done_cleared", done1, 0);
    exp1_q.push_back({32'h2000, 32'h04030201});
    exp1_q.push_back({32'h2004, 32'h00000605});
    for (int i = 1; i <= 6; i++) send(0, 8'(i), i == 6);
    wait_flag(0, "t2_done");
    check("t2_words", ww1, 2);
    check_writes(0, "t2_write");

    // Back-to-back bytes across two WRITE cycles
    pulse_start(0);
    exp1_q.push_back({32'h2000, 32'h13121110});
    exp1_q.push_back({32'h2004, 32'h17161514});
    for (int i = 0; i < 8; i++) send(0, 8'(8'h10 + i), i == 7);
    wait_flag(0, "t3_done");
    check("t3_words", ww1, 2);
    check("t3_ready_in_write", viol, 0);
    check_writes(0, "t3_write");

    // Overflow on the small instance
    pulse_start(1);
    exp2_q.push_back({32'h2000, 32'h23222120});
    exp2_q.push_back({32'h2004, 32'h27262524});
    for (int i = 0; i < 12; i++) send(1, 8'(8'h20 + i), 0);
    wait_flag(1, "t4_error");
    repeat (3) @(negedge clk);
    check("t4_error", err2, 1);
    check("t4_core_reset", crst2, 1);
    check("t4_done", done2, 0);
    check("t4_in_ready", s2.in_ready, 0);
    check("t4_words", ww2, 2);
    check_writes(1, "t4_write");
    pulse_start(1);
    check("t4_error_cleared", err2, 0);

    // Reset mid-load, then a clean reload
    pulse_start(0);
    send(0, 8'hAA, 0); send(0, 8'hBB, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_no_write", obs1_q.size(), 0);
    check("t5_in_ready", s1.in_ready, 0);
    check("t5_core_reset", crst1, 1);
    pulse_start(0);
    exp1_q.push_back({32'h2000, 32'hDDCCBBAA});
    send(0, 8'hAA, 0); send(0, 8'hBB, 0); send(0, 8'hCC, 0); send(0, 8'hDD, 1);
    wait_flag(0, "t5_done");
    check_writes(0, "t5_write");

    // Checksum wrap; stray in_last without valid and start mid-load are ignored
    pulse_start(0);
    s1.in_last = 1'b1;
    repeat (3) @(negedge clk);
    s1.in_last = 1'b0;
    exp1_q.push_back({32'h2000, 32'h040302FF});
    send(0, 8'hFF, 0);
    pulse_start(0);
    send(0, 8'h02, 0); send(0, 8'h03, 0); send(0, 8'h04, 1);
    wait_flag(0, "t6_done");
    check("t6_words", ww1, 1);
`ifdef TINKER_LOADER_CHECKSUM_EN
    check("t6_checksum", cks1, 8'h08);
`else
    check("t6_checksum", cks1, 8'h00);
`endif
    check_writes(0, "t6_write");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tinker_program_loader.md
Name: tinker_program_loader

Overview:
Writer side of the Tinker instruction-fetch path. It accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit instruction words. Each word is written into unified memory starting at the code base address (0x2000). The loader holds the core in reset until the image is fully written, then releases it.

Parameters:
BASE_ADDR, 64'h2000, byte address of the first instruction word (core reset PC).
MEM_BYTES, 524288, memory size in bytes; a write whose last byte would fall at or beyond this is an overflow.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a load (ignored in COLLECT/WRITE)
in_valid  input  1  stream byte valid
in_data  input  8  stream byte
in_last  input  1  marks final byte of image (qualified by in_valid)
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  one-cycle word write strobe
mem_addr  output  32  byte address of word write (always 4-aligned)
mem_wdata  output  32  little-endian packed word
core_reset  output  1  holds tinker_core in reset while high
done  output  1  image loaded, core released
error  output  1  overflow detected; sticky until reset/start
words_written  output  32  count of words written this load
checksum  output  8  running byte sum (see Optional Feature)

Behaviour:
- Uses one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, done=0, error=0, words_written=0, checksum=0. FSM resets to IDLE.
- States: IDLE, COLLECT, WRITE, DONE, ERR.
- IDLE: in_ready=0, core_reset=1. On start, go to COLLECT; clear byte index, packer, words_written, checksum and error.
- COLLECT: in_ready=1. A byte is accepted on in_valid&in_ready. Byte k (k=0..3) lands in packer bits [8k+7:8k].
- COLLECT exit: on accepting the 4th byte, or any byte with in_last, go to WRITE next cycle. Unfilled upper bytes are zero.
- Overflow check: before entering WRITE, if BASE_ADDR+4*words_written+3 >= MEM_BYTES, go to ERR instead. No write occurs.
- WRITE: exactly one cycle. mem_we=1, mem_addr=BASE_ADDR+4*words_written (truncated to 32 bits), mem_wdata=packer, in_ready=0. Next cycle words_written increments and the byte index clears. Go to DONE if the word carried in_last, else COLLECT.
- Throughput: 4 bytes per 5 cycles minimum. A byte presented during WRITE is not consumed; the source holds it.
- DONE: core_reset=0, done=1, in_ready=0. A start pulse re-enters COLLECT with core_reset=1, done=0 and counters cleared.
- ERR: error=1, core_reset=1, in_ready=0. Only reset or start leaves this state (start behaves as from IDLE).
- start while in COLLECT/WRITE is ignored.
- in_last with in_valid low is ignored.
- Reset mid-load: returns to IDLE immediately. The partial word is discarded, mem_we=0, and the next load restarts at BASE_ADDR.

Optional Feature:
TINKER_LOADER_CHECKSUM_EN
- Defined: checksum = sum of all accepted bytes mod 256, updated the cycle after acceptance, cleared on start.
- Not defined: checksum is tied to 8'h00 and the adder is omitted. The port still exists.

Decomposition:
- tinker_pkg: loader_state_t enum, TINKER_CODE_BASE=64'h2000, TINKER_MEM_BYTES=524288.
- Sub-module le_byte_packer: byte-index counter plus 32-bit little-endian shift/insert with clear. The FSM and address/overflow logic stay in the top.

Test Plan:
- start; bytes 13,57,9B,DF with in_last on DF -> single mem_we at 0x2000, wdata 0xDF9B5713; done=1, core_reset=0, words_written=1.
- bytes 01..06, in_last on 06 -> writes 0x04030201@0x2000 and 0x00000605@0x2004; words_written=2.
- in_valid held high continuously for 8 bytes -> in_ready=0 in both WRITE cycles, no byte lost or duplicated, words at 0x2000/0x2004 correct.
- MEM_BYTES=0x2008, 12 bytes streamed -> writes at 0x2000 and 0x2004 only, error=1, core_reset stays 1, no mem_we at 0x2008.
- reset asserted after 2 bytes accepted -> mem_we never pulses; a new start plus AA,BB,CC,DD(last) writes 0xDDCCBBAA@0x2000.
- With TINKER_LOADER_CHECKSUM_EN: bytes FF,02,03,04 -> checksum=0x08; without the macro, checksum=0x00.
